// File: rtl/ysyx_25020037_lsu.sv
// ysyx_25020037_lsu: multi-cycle load/store unit.
//
// Accepts one memory op from the execute stage over a valid/ready handshake,
// issues one request on the data memory bus, waits for the response or ack,
// and then spends one DONE cycle driving the register-file write port.
// The DONE cycle pulses done. It raises gpr_wen only for a legal load.
//
// FSM: IDLE -> REQ -> WAIT -> DONE -> IDLE. Illegal or non-memory ops skip
// straight from IDLE to DONE without touching the bus.
//
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   in_*                op from EXU (valid/ready, addr, store data, funct3,
//                       load/store flags, rd)
//   mem_req_*, mem_*    request channel (valid/ready, addr, wen, lane-replicated
//                       wdata, byte mask) and response (rsp_valid, rdata)
//   gpr_waddr/wdata/wen one-cycle register file writeback
//   done                transaction-complete pulse
//   misalign            misaligned-access flag
//
// Optional feature macro: YSYX_25020037_LSU_MISALIGN_CHK_EN
//   defined   : misaligned half/word ops finish in DONE with misalign=1,
//               no bus request and no writeback
//   undefined : misalign stays 0 and every access is issued as-is
module ysyx_25020037_lsu #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    input  logic [2:0]    in_funct3,
    input  logic          in_is_load,
    input  logic          in_is_store,
    input  logic [4:0]    in_rd,
    output logic          mem_req_valid,
    input  logic          mem_req_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_wen,
    output logic [DW-1:0] mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic          mem_rsp_valid,
    input  logic [DW-1:0] mem_rdata,
    output logic [4:0]    gpr_waddr,
    output logic [DW-1:0] gpr_wdata,
    output logic          gpr_wen,
    output logic          done,
    output logic          misalign
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t     state;
    logic [1:0] lane_q;
    logic [2:0] funct3_q;
    logic       is_load_q;
    logic [4:0] rd_q;

    logic ld_ok, st_ok, mem_op, mis_hit;

    // Byte strobes: byte lane from addr[1:0], half lane from addr[1].
    function automatic logic [DW/8-1:0] store_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 4'b0001 << lane;
            2'b01:   return 4'b0011 << {lane[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across all lanes so the mask alone selects bytes.
    function automatic logic [DW-1:0] store_data(input logic [1:0] size, input logic [DW-1:0] wd);
        case (size)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [DW-1:0] load_data(input logic [2:0] f3, input logic [1:0] lane,
                                                input logic [DW-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[8*lane +: 8];
        h = lane[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return rd;
        endcase
    endfunction

    // A set is_load wins over is_store if both are presented.
    always_comb begin
        ld_ok  = in_is_load && (in_funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        st_ok  = !in_is_load && in_is_store && (in_funct3 < 3'd3);
        mem_op = ld_ok || st_ok;
    end

`ifdef YSYX_25020037_LSU_MISALIGN_CHK_EN
    assign mis_hit = mem_op && ((in_funct3[1:0] == 2'b01 && in_addr[0]) ||
                                (in_funct3[1:0] == 2'b10 && in_addr[1:0] != 2'b00));
`else
    assign mis_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            in_ready      <= 1'b1;
            mem_req_valid <= 1'b0;
            mem_addr      <= '0;
            mem_wen       <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            gpr_waddr     <= '0;
            gpr_wdata     <= '0;
            gpr_wen       <= 1'b0;
            done          <= 1'b0;
            misalign      <= 1'b0;
            lane_q        <= '0;
            funct3_q      <= '0;
            is_load_q     <= 1'b0;
            rd_q          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready  <= 1'b0;
                        lane_q    <= in_addr[1:0];
                        funct3_q  <= in_funct3;
                        is_load_q <= ld_ok;
                        rd_q      <= in_rd;
                        if (mem_op && !mis_hit) begin
                            state         <= REQ;
                            mem_req_valid <= 1'b1;
                            mem_addr      <= in_addr;
                            mem_wen       <= st_ok;
                            mem_wdata     <= st_ok ? store_data(in_funct3[1:0], in_wdata) : '0;
                            mem_wmask     <= st_ok ? store_mask(in_funct3[1:0], in_addr[1:0]) : '0;
                        end else begin
                            // No bus access: finish immediately without writeback.
                            state     <= DONE;
                            done      <= 1'b1;
                            gpr_wen   <= 1'b0;
                            gpr_waddr <= in_rd;
                            misalign  <= mis_hit;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) begin
                        state         <= WAIT;
                        mem_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        gpr_wen   <= is_load_q;
                        gpr_waddr <= rd_q;
                        gpr_wdata <= is_load_q ? load_data(funct3_q, lane_q, mem_rdata) : '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    done      <= 1'b0;
                    gpr_wen   <= 1'b0;
                    gpr_waddr <= '0;
                    gpr_wdata <= '0;
                    misalign  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
module tb_ysyx_25020037_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_addr;
    logic [31:0] in_wdata;
    logic [2:0]  in_funct3;
    logic        in_is_load;
    logic        in_is_store;
    logic [4:0]  in_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        gpr_wen;
    logic        done;
    logic        misalign;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ysyx_25020037_lsu #(.AW(32), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_funct3(in_funct3), .in_is_load(in_is_load), .in_is_store(in_is_store), .in_rd(in_rd),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata), .gpr_wen(gpr_wen),
        .done(done), .misalign(misalign)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit legal(input bit ld, input bit st, input logic [2:0] f3);
        if (ld) return (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        if (st) return (f3 <= 2);
        return 0;
    endfunction

    function automatic bit misal(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a);
`ifdef YSYX_25020037_LSU_MISALIGN_CHK_EN
        return legal(ld, st, f3) && ((a % nbytes(f3)) != 0);
`else
        return 0;
`endif
    endfunction

    // Offset of the accessed lane inside the word: aligned down to the access size.
    function automatic int lane_off(input logic [2:0] f3, input logic [31:0] a);
        int n;
        n = nbytes(f3);
        return ((a % 4) / n) * n;
    endfunction

    function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
        int n;
        logic [7:0] m;
        n = nbytes(f3);
        m = 8'((1 << n) - 1) << lane_off(f3, a);
        return m[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] r;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int n;
        logic [63:0] m, v;
        n = nbytes(f3);
        m = (64'd1 << (8 * n)) - 64'd1;
        v = ({32'b0, rd} >> (8 * lane_off(f3, a))) & m;
        if (f3 < 4 && v[8*n-1]) v = v | ~m;
        return v[31:0];
    endfunction

    // One complete transaction, with checks at every stage.
    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] rdata,
                         input int rdy_dly, input int rsp_dly, input bit hold);
        bit is_ld, exp_mem, exp_mis;
        is_ld   = ld;
        exp_mem = legal(ld, st, f3) && !misal(ld, st, f3, a);
        exp_mis = misal(ld, st, f3, a);

        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_addr = a; in_wdata = wd; in_funct3 = f3;
        in_is_load = ld; in_is_store = st; in_rd = rd;
        tick();
        if (hold) begin
            in_addr = $urandom; in_wdata = $urandom; in_rd = 5'($urandom);
            in_is_load = 1'b1; in_funct3 = 3'd2;
        end else begin
            in_valid = 1'b0;
        end

        if (exp_mem) begin
            check("req_valid", 32'(mem_req_valid), 32'd1);
            check("req_in_ready", 32'(in_ready), 32'd0);
            check("req_addr", mem_addr, a);
            check("req_wen", 32'(mem_wen), 32'(!is_ld));
            check("req_wmask", 32'(mem_wmask), is_ld ? 32'd0 : 32'(exp_mask(f3, a)));
            if (!is_ld) check("req_wdata", mem_wdata, exp_wdata(f3, wd));
            for (int k = 0; k < rdy_dly; k++) begin
                mem_rsp_valid = 1'($urandom);
                mem_rdata = $urandom;
                tick();
                check("stall_valid", 32'(mem_req_valid), 32'd1);
                check("stall_addr", mem_addr, a);
                check("stall_wmask", 32'(mem_wmask), is_ld ? 32'd0 : 32'(exp_mask(f3, a)));
                if (!is_ld) check("stall_wdata", mem_wdata, exp_wdata(f3, wd));
                check("stall_done", 32'(done), 32'd0);
            end
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0;
            check("wait_req_valid", 32'(mem_req_valid), 32'd0);
            check("wait_done", 32'(done), 32'd0);
            for (int k = 0; k < rsp_dly; k++) begin
                tick();
                check("wait_hold_done", 32'(done), 32'd0);
            end
            mem_rdata = rdata;
            mem_rsp_valid = 1'b1;
            tick();
            mem_rsp_valid = 1'b0;
            mem_rdata = $urandom;
        end

        check("done_pulse", 32'(done), 32'd1);
        check("done_gpr_wen", 32'(gpr_wen), 32'(exp_mem && is_ld));
        check("done_gpr_waddr", 32'(gpr_waddr), 32'(rd));
        if (exp_mem && is_ld) check("done_gpr_wdata", gpr_wdata, exp_load(f3, a, rdata));
        check("done_misalign", 32'(misalign), 32'(exp_mis));
        check("done_in_ready", 32'(in_ready), 32'd0);
        check("done_req_valid", 32'(mem_req_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        check("post_done", 32'(done), 32'd0);
        check("post_gpr_wen", 32'(gpr_wen), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_misalign", 32'(misalign), 32'd0);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_funct3 = '0;
        in_is_load = 1'b0; in_is_store = 1'b0; in_rd = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        tick(); tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_gpr_wen", 32'(gpr_wen), 32'd0);
        check("rst_gpr_wdata", gpr_wdata, 32'd0);
        check("rst_wmask", 32'(mem_wmask), 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b1;
        tick();

        // Reset while waiting for a response; the late response must be ignored.
        in_valid = 1'b1; in_is_load = 1'b1; in_is_store = 1'b0; in_funct3 = 3'd2;
        in_addr = 32'h8000_0000; in_rd = 5'd7;
        tick();
        in_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("midwait_req_valid", 32'(mem_req_valid), 32'd0);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("midwait_rst_ready", 32'(in_ready), 32'd1);
        mem_rsp_valid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        check("late_rsp_done", 32'(done), 32'd0);
        check("late_rsp_gpr_wen", 32'(gpr_wen), 32'd0);
        check("late_rsp_ready", 32'(in_ready), 32'd1);
        tick();
        check("late_rsp_done2", 32'(done), 32'd0);

        // Directed cases.
        do_op(1, 0, 3'd0, 32'h8000_0003, 32'h0, 5'd5, 32'h80FF_FFFF, 0, 0, 0);   // LB
        do_op(1, 0, 3'd5, 32'h8000_0002, 32'h0, 5'd9, 32'hBEEF_1234, 0, 0, 0);   // LHU
        do_op(0, 1, 3'd0, 32'h8000_0001, 32'h0000_00AB, 5'd3, 32'h0, 3, 0, 0);  // SB, stalled
        do_op(0, 1, 3'd2, 32'h8000_0004, 32'h1234_5678, 5'd4, 32'h0, 0, 1, 1);  // SW, in_valid held
        do_op(1, 0, 3'd2, 32'h8000_0002, 32'h0, 5'd6, 32'hCAFE_F00D, 0, 0, 0);   // LW misaligned
        do_op(1, 0, 3'd1, 32'h8000_0001, 32'h0, 5'd8, 32'h1122_8344, 1, 2, 0);   // LH odd
        do_op(1, 0, 3'd2, 32'h8000_0008, 32'h0, 5'd0, 32'h0BAD_F00D, 0, 0, 0);   // LW rd=0
        do_op(1, 0, 3'd3, 32'h8000_0000, 32'h0, 5'd1, 32'h0, 0, 0, 0);           // illegal load
        do_op(0, 1, 3'd3, 32'h8000_0000, 32'h5555_5555, 5'd2, 32'h0, 0, 0, 0);   // illegal store
        do_op(0, 0, 3'd2, 32'h8000_0000, 32'h0, 5'd2, 32'h0, 0, 0, 0);           // neither

        // Randomised transactions.
        for (int i = 0; i < 60; i++) begin
            int kind;
            bit ld, st;
            kind = int'($urandom_range(0, 9));
            ld = (kind < 5);
            st = (kind >= 5 && kind < 9);
            do_op(ld, st, 3'($urandom), 32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom,
                  5'($urandom), $urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ysyx_25020037_lsu.md
Name: ysyx_25020037_lsu

Overview:
Multi-cycle load/store unit between the execute stage and the register file write port. Accepts one memory op per transaction over a valid/ready handshake and issues a single request to the data memory bus. Waits for the response, then drives one-cycle writeback signals gpr_waddr/gpr_wdata/gpr_wen into the register file. Handles byte/half/word sizing, store masks and load sign/zero extension.

Parameters:
AW, 32, address width
DW, 32, data width (fixed 32; mask width DW/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
in_valid  in  1  EXU op valid
in_ready  out  1  LSU can accept (IDLE only)
in_addr  in  32  effective address
in_wdata  in  32  store data (rs2)
in_funct3  in  3  RV32I size/sign code
in_is_load  in  1  op is load
in_is_store  in  1  op is store
in_rd  in  5  destination register
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  32  request address
mem_wen  out  1  1 = write
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte strobes
mem_rsp_valid  in  1  response/ack valid
mem_rdata  in  32  read data
gpr_waddr  out  5  writeback register index
gpr_wdata  out  32  writeback data
gpr_wen  out  1  writeback enable (1 cycle)
done  out  1  transaction-complete pulse
misalign  out  1  misaligned-access flag (see optional feature)

Behaviour:
- rst low at posedge: state=IDLE; every output 0 except in_ready=1; captured fields cleared.
- FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
- IDLE: in_ready=1. Accept on in_valid&in_ready; latch addr, wdata, funct3, is_load, is_store, rd. Neither load nor store, or illegal funct3 (load 3/6/7; store >=3) -> DONE directly, no memory access, gpr_wen=0.
- REQ: mem_req_valid=1; mem_addr/mem_wen/mem_wdata/mem_wmask held stable until mem_req_ready; handshake -> WAIT.
- WAIT: mem_req_valid=0; mem_rsp_valid -> latch mem_rdata, go DONE. Stores also wait for the ack.
- DONE: exactly one cycle with done=1; gpr_wen=1 only for a legal load; gpr_waddr=rd; then IDLE. in_ready=0 in DONE.
- Store sizing: SB mask=0001<<addr[1:0], data={4{wdata[7:0]}}; SH mask=0011<<{addr[1],1'b0}, data={2{wdata[15:0]}}; SW mask=1111, data=wdata. mem_addr=in_addr unmodified. Loads: mem_wen=0, mask=0000.
- Load extract: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend, LW whole word.
- gpr_wen asserted for rd=0 too (register file discards x0 writes).
- Minimum latency: accept at T, REQ at T+1; ready at T+1 -> WAIT at T+2; rsp at T+2 -> DONE at T+3.
- mem_rsp_valid outside WAIT is ignored. Reset in any state aborts the transaction; a late response is ignored.

Optional Feature:
YSYX_25020037_LSU_MISALIGN_CHK_EN:
- Defined: at accept, half with addr[0]=1 or word with addr[1:0]!=0 -> straight to DONE with misalign=1 for that cycle, gpr_wen=0, no memory request.
- Undefined: misalign tied 0; access issued as-is.

Test Plan:
- Reset mid-WAIT (rst=0 one cycle), then mem_rsp_valid=1 -> state IDLE, in_ready=1, done/gpr_wen stay 0.
- LB addr=0x80000003, mem_rdata=0x80FFFFFF, rd=5, ready/rsp immediate -> DONE at T+3: gpr_waddr=5, gpr_wdata=0xFFFFFF80, gpr_wen=1.
- LHU addr=0x80000002, mem_rdata=0xBEEF1234 -> gpr_wdata=0x0000BEEF.
- SB addr=0x80000001, wdata=0x000000AB, mem_req_ready delayed 3 cycles -> mem_wmask=0010 and mem_wdata=0xABABABAB held stable through stall; done=1 after ack, gpr_wen=0.
- SW addr=0x80000004, wdata=0x12345678 -> mem_wen=1, mask=1111, data=0x12345678. Back-to-back: second op not accepted until IDLE.
- With macro: LW addr=0x80000002 -> no mem_req_valid, DONE next cycle, misalign=1, gpr_wen=0. Without macro: request issued, misalign=0.
